cal_sequencer: RTL and testbench
================================

// Module: cal_sequencer
// PURPOSE
//  Control FSM for the calculator datapath (converter, signed, shift, bitwise, logic units).
//  - Turns raw confirm/store/button_press levels into single-cycle pulses.
//  - Selects the mode, rotates the operator, and captures operands A and B from the switches.
//  - Tells the display mux when the result is valid.
//  - The compute units remain combinational and are driven from mode/op/a/b.
// PARAMETERS
//  WIDTH     8  operand width (switch bus, a, b)
//  NUM_MODES 5  one-hot modes: BIN=00001, SGN=00010, SHF=00100, BIT=01000, LOG=10000
// PORTS
//  clk           in   1      system clock
//  reset         in   1      synchronous, active-low reset
//  confirm       in   1      raw level; enter/exit operand entry
//  store         in   1      raw level; capture switches into next operand
//  button_press  in   1      raw level; next mode (IDLE) or next op (otherwise)
//  in            in   WIDTH  switch value
//  mode          out  5      one-hot current mode
//  op            out  4      one-hot operator
//  a             out  WIDTH  operand A register
//  b             out  WIDTH  operand B register
//  phase         out  2      00 IDLE, 01 WAIT_A, 10 WAIT_B, 11 SHOW
//  result_valid  out  1      high in SHOW: display mux shows the unit result, else shows `in`
//  store_ack     out  1      one-cycle pulse on each accepted capture
// BEHAVIOUR
//  Reset (reset==0 at posedge clk):
//  - mode=BIN, op=0001, a=b=0, phase=IDLE, result_valid=0, store_ack=0.
//  - Edge-detect history registers are cleared to 0.
//  Edge detect: pulse = level & ~level_d1, one cycle, registered once; a held button yields exactly one pulse.
//  Same-cycle pulses: priority is confirm > store > button_press; lower-priority pulses are dropped.
//  Per-mode operator count NOPS:
//  - BIN: 2; op rotates 0001 -> 0010 -> 0001.
//  - all other modes: 4; op rotates 0001 -> 0010 -> 0100 -> 1000 -> 0001.
//  FSM states:
//  - IDLE:
//    - button_press: mode rotates BIN -> SGN -> SHF -> BIT -> LOG -> BIN; op <= 0001.
//    - confirm: -> WAIT_A.
//    - store: ignored.
//  - WAIT_A:
//    - store: a <= in, store_ack=1.
//    - then, if mode==BIN, -> SHOW; else -> WAIT_B.
//  - WAIT_B:
//    - store: b <= in, store_ack=1, -> SHOW.
//  - SHOW:
//    - store: a <= in, store_ack=1, b is kept.
//    - then, if mode==BIN, stay in SHOW; else -> WAIT_B (chained calculation).
//  - Any of WAIT_A, WAIT_B, SHOW:
//    - button_press: op advances, a/b untouched.
//    - confirm: -> IDLE; a/b retained; result_valid drops the next cycle.
//  Timing:
//  - result_valid is registered; it is 1 exactly when phase==SHOW, i.e. one cycle after the store edge.
//  - Latency from raw store rising edge to result_valid: 2 clocks (1 for edge detect, 1 for state).
//  Illegal values:
//  - mode/op not one-hot, or op outside NOPS: recovers to BIN / 0001 on the next clock.
//  - phase has no illegal encodings.
//  Mid-operation reset: reset has priority over every pulse; partially entered operands are cleared.
//  Widths: a/b are captured unmodified, with no sign extension; the units interpret them.
// STRUCTURE
//  Package cal_pkg:
//  - MODE_* localparams.
//  - OP_* one-hot constants.
//  - PH_IDLE/PH_WAIT_A/PH_WAIT_B/PH_SHOW.
//  - nops(mode) function.
//  Sub-module btn_pulse (1 instance per button):
//  - Registers the level and outputs a rising-edge pulse.
//  - Synchronous active-low reset.
//  The top holds one FSM always block, plus the op/mode/operand registers.
// TESTING
//  - Reset then idle 10 clks -> mode=00001, op=0001, phase=00, a=b=0, result_valid=0.
//  - IDLE, button_press held 5 clks -> mode advances once to 00010; press 4 more times -> wraps to 00001.
//  - SGN mode: confirm, in=8'h05 store, in=8'hFB store -> a=05, b=FB, phase=11.
//    - store_ack pulsed twice; result_valid=1 two clks after the 2nd store edge.
//  - BIN mode: confirm, in=8'hA3 store -> phase=11 directly, a=A3.
//    - button_press x3 -> op=0001 -> 0010 -> 0001 -> 0010.
//  - confirm and store rising in the same clk while in WAIT_B -> phase=00; b unchanged; no store_ack.
//  - reset=0 for 1 clk while in WAIT_B with a=7F -> a=0, phase=00, mode=00001 on that edge.

Source files
------------

// File: rtl/cal_sequencer_pkg.sv
// cal_pkg: shared widths, one-hot mode/op constants, phase encoding and per-mode operator count
package cal_pkg;
  localparam int WIDTH = 8;
  localparam int NUM_MODES = 5;
  localparam int NUM_OPS = 4;
  localparam logic [NUM_MODES-1:0] MODE_BIN = 5'b00001;
  localparam logic [NUM_MODES-1:0] MODE_SGN = 5'b00010;
  localparam logic [NUM_MODES-1:0] MODE_SHF = 5'b00100;
  localparam logic [NUM_MODES-1:0] MODE_BIT = 5'b01000;
  localparam logic [NUM_MODES-1:0] MODE_LOG = 5'b10000;
  localparam logic [NUM_OPS-1:0] OP_1 = 4'b0001;
  localparam logic [NUM_OPS-1:0] OP_2 = 4'b0010;
  localparam logic [NUM_OPS-1:0] OP_3 = 4'b0100;
  localparam logic [NUM_OPS-1:0] OP_4 = 4'b1000;
  typedef enum logic [1:0] {PH_IDLE = 2'b00, PH_WAIT_A = 2'b01, PH_WAIT_B = 2'b10, PH_SHOW = 2'b11} phase_e;
  function automatic logic [2:0] nops(input logic [NUM_MODES-1:0] m);
    return (m == MODE_BIN) ? 3'd2 : 3'd4;
  endfunction
endpackage

// File: rtl/cal_sequencer_if.sv
// cal_sequencer_if: raw button levels and switch value in; mode/op/operands/phase/result_valid/store_ack out
interface cal_sequencer_if #(parameter int WIDTH = 8);
  logic confirm;
  logic store;
  logic button_press;
  logic [WIDTH-1:0] in;
  logic [4:0] mode;
  logic [3:0] op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0] phase;
  logic result_valid;
  logic store_ack;
  modport master (output confirm, store, button_press, in, input mode, op, a, b, phase, result_valid, store_ack);
  modport slave (input confirm, store, button_press, in, output mode, op, a, b, phase, result_valid, store_ack);
endinterface

// File: rtl/cal_sequencer_btn_pulse.sv
// btn_pulse: clk, reset (sync active-low), level_i raw level, pulse_o registered one-cycle rising-edge pulse
module btn_pulse (
  input  logic clk,
  input  logic reset,
  input  logic level_i,
  output logic pulse_o
);
  logic level_q, pulse_q;
  always_ff @(posedge clk) begin
    if (!reset) begin
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      level_q <= level_i;
      pulse_q <= level_i & ~level_q;
    end
  end
  assign pulse_o = pulse_q;
endmodule

// File: rtl/cal_sequencer.sv
// cal_sequencer: clk, reset (sync active-low), bus slave: button levels/switches in, mode/op/a/b/phase/result_valid/store_ack out
module cal_sequencer
  import cal_pkg::*;
(
  input logic clk,
  input logic reset,
  cal_sequencer_if.slave bus
);
  logic cp, sp, bp;
  btn_pulse u_confirm (.clk(clk), .reset(reset), .level_i(bus.confirm), .pulse_o(cp));
  btn_pulse u_store (.clk(clk), .reset(reset), .level_i(bus.store), .pulse_o(sp));
  btn_pulse u_button (.clk(clk), .reset(reset), .level_i(bus.button_press), .pulse_o(bp));
  phase_e phase_q, phase_d;
  logic [NUM_MODES-1:0] mode_q, mode_d, mode_c;
  logic [NUM_OPS-1:0] op_q, op_d, op_c, op_top;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic rv_q, ack_q, ack_d;
  always_ff @(posedge clk) begin
    if (!reset) begin
      phase_q <= PH_IDLE;
      mode_q <= MODE_BIN;
      op_q <= OP_1;
      a_q <= '0;
      b_q <= '0;
      rv_q <= 1'b0;
      ack_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      mode_q <= mode_d;
      op_q <= op_d;
      a_q <= a_d;
      b_q <= b_d;
      rv_q <= (phase_d == PH_SHOW);
      ack_q <= ack_d;
    end
  end
  always_comb begin
    mode_c = $onehot(mode_q) ? mode_q : MODE_BIN;
    op_top = OP_1 << (nops(mode_c) - 3'd1);
    op_c = ($onehot(op_q) && op_q <= op_top) ? op_q : OP_1;
    phase_d = phase_q;
    mode_d = mode_c;
    op_d = op_c;
    a_d = a_q;
    b_d = b_q;
    ack_d = 1'b0;
    if (cp) begin
      phase_d = (phase_q == PH_IDLE) ? PH_WAIT_A : PH_IDLE;
    end else if (sp && phase_q != PH_IDLE) begin
      ack_d = 1'b1;
      b_d = (phase_q == PH_WAIT_B) ? bus.in : b_q;
      a_d = (phase_q == PH_WAIT_B) ? a_q : bus.in;
      phase_d = (phase_q == PH_WAIT_B || mode_c == MODE_BIN) ? PH_SHOW : PH_WAIT_B;
    end else if (bp) begin
      mode_d = (phase_q == PH_IDLE) ? (mode_c[NUM_MODES-1] ? MODE_BIN : mode_c << 1) : mode_c;
      op_d = (phase_q == PH_IDLE || op_c == op_top) ? OP_1 : op_c << 1;
    end
  end
  assign bus.mode = mode_q;
  assign bus.op = op_q;
  assign bus.a = a_q;
  assign bus.b = b_q;
  assign bus.phase = phase_q;
  assign bus.result_valid = rv_q;
  assign bus.store_ack = ack_q;
endmodule

// File: tb/tb_cal_sequencer.sv
// tb_cal_sequencer: directed plus randomized stimulus against an index-based behavioural model
module tb_cal_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b0;
  cal_sequencer_if #(.WIDTH(8)) bus ();
  cal_sequencer dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  int errors = 0;
  int checks = 0;
  int m_mode, m_op, m_ph;
  logic [7:0] m_a, m_b;
  bit m_ack;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    m_mode = 0; m_op = 0; m_ph = 0; m_a = 8'h00; m_b = 8'h00; m_ack = 1'b0;
  endtask
  task automatic model_apply(input bit c, input bit s, input bit p, input logic [7:0] v);
    m_ack = 1'b0;
    if (c) m_ph = (m_ph == 0) ? 1 : 0;
    else if (s && m_ph != 0) begin
      m_ack = 1'b1;
      if (m_ph == 2) begin m_b = v; m_ph = 3; end
      else begin m_a = v; m_ph = (m_mode == 0) ? 3 : 2; end
    end else if (p) begin
      if (m_ph == 0) begin m_mode = (m_mode + 1) % 5; m_op = 0; end
      else m_op = (m_op + 1) % ((m_mode == 0) ? 2 : 4);
    end
  endtask
  task automatic check_all(input string tag);
    check({tag, ".mode"}, 32'(bus.mode), 32'(1) << m_mode);
    check({tag, ".op"}, 32'(bus.op), 32'(1) << m_op);
    check({tag, ".phase"}, 32'(bus.phase), 32'(m_ph));
    check({tag, ".a"}, 32'(bus.a), 32'(m_a));
    check({tag, ".b"}, 32'(bus.b), 32'(m_b));
    check({tag, ".rv"}, 32'(bus.result_valid), 32'(m_ph == 3));
    check({tag, ".ack"}, 32'(bus.store_ack), 32'(m_ack));
  endtask
  task automatic press(input string tag, input bit c, input bit s, input bit p, input logic [7:0] v, input int hold);
    bus.confirm = c; bus.store = s; bus.button_press = p; bus.in = v;
    @(posedge clk);
    @(posedge clk); #1;
    model_apply(c, s, p, v);
    check_all(tag);
    m_ack = 1'b0;
    for (int i = 1; i < hold; i++) begin
      @(posedge clk); #1;
      check_all({tag, ".held"});
    end
    bus.confirm = 1'b0; bus.store = 1'b0; bus.button_press = 1'b0;
    @(posedge clk); #1;
    check({tag, ".ack_low"}, 32'(bus.store_ack), 32'(0));
  endtask
  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    model_reset();
    reset = 1'b1;
  endtask
  initial begin
    bus.confirm = 1'b0; bus.store = 1'b0; bus.button_press = 1'b0; bus.in = 8'h00;
    model_reset();
    @(posedge clk); #1;
    do_reset();
    repeat (10) @(posedge clk);
    #1;
    check_all("reset_idle");
    press("hold_btn", 0, 0, 1, 8'h00, 5);
    for (int i = 0; i < 4; i++) press("mode_wrap", 0, 0, 1, 8'h00, 1);
    check("mode_wrapped", 32'(bus.mode), 32'h01);
    press("to_sgn", 0, 0, 1, 8'h00, 1);
    press("sgn_confirm", 1, 0, 0, 8'h00, 1);
    press("sgn_store_a", 0, 1, 0, 8'h05, 1);
    press("sgn_store_b", 0, 1, 0, 8'hFB, 1);
    check("sgn_result", {bus.a, bus.b, 14'd0, bus.phase}, {8'h05, 8'hFB, 14'd0, 2'b11});
    press("sgn_exit", 1, 0, 0, 8'h00, 1);
    for (int i = 0; i < 4; i++) press("back_bin", 0, 0, 1, 8'h00, 1);
    press("bin_confirm", 1, 0, 0, 8'h00, 1);
    press("bin_store", 0, 1, 0, 8'hA3, 2);
    check("bin_show", {bus.a, 22'd0, bus.phase}, {8'hA3, 22'd0, 2'b11});
    for (int i = 0; i < 3; i++) press("bin_op", 0, 0, 1, 8'h00, 1);
    check("bin_op_final", 32'(bus.op), 32'h2);
    press("bin_store_show", 0, 1, 0, 8'h3C, 1);
    press("exit2", 1, 0, 0, 8'h00, 1);
    press("to_sgn2", 0, 0, 1, 8'h00, 1);
    press("c2", 1, 0, 0, 8'h00, 1);
    press("a2", 0, 1, 0, 8'h11, 1);
    press("b2", 0, 1, 0, 8'h22, 1);
    press("chain_a", 0, 1, 0, 8'h33, 1);
    check("chain_phase", 32'(bus.phase), 32'h2);
    press("conf_store_same", 1, 1, 0, 8'h99, 1);
    check("same_b_kept", 32'(bus.b), 32'h22);
    press("c3", 1, 0, 0, 8'h00, 1);
    press("a3", 0, 1, 0, 8'h7F, 1);
    reset = 1'b0;
    @(posedge clk); #1;
    model_reset();
    check_all("mid_reset");
    reset = 1'b1;
    for (int n = 0; n < 150; n++) begin
      bit c, s, p;
      c = ($urandom_range(0, 5) == 0);
      s = ($urandom_range(0, 2) == 0);
      p = ($urandom_range(0, 2) == 0);
      if (!c && !s && !p) p = 1'b1;
      press("rand", c, s, p, 8'($urandom), $urandom_range(1, 3));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
